// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: IF-side push port, ID-side head/pop port, flush and occupancy.
// Ports: in_* (IF -> queue, with in_ready back), *_out/out_valid (queue -> ID, with out_ready back),
//        flush (redirect from the back end), count (occupancy seen by the back end).
interface fetch_queue_if #(
  parameter int DEPTH     = 8,
  parameter int GHR_WIDTH = 5
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic                 is_branch_taken_in;
  logic [GHR_WIDTH-1:0] pht_index_in;
  logic [31:0]          pc_in;
  logic [31:0]          inst_in;
  logic                 out_valid;
  logic                 out_ready;
  logic                 is_branch_taken_out;
  logic [GHR_WIDTH-1:0] pht_index_out;
  logic [31:0]          pc_out;
  logic [31:0]          inst_out;
  logic [CW-1:0]        count;

  // The queue itself.
  modport slave (
    input  flush, in_valid, is_branch_taken_in, pht_index_in, pc_in, inst_in, out_ready,
    output in_ready, out_valid, is_branch_taken_out, pht_index_out, pc_out, inst_out, count
  );

  // The surrounding pipeline (IF producer + ID consumer).
  modport master (
    output flush, in_valid, is_branch_taken_in, pht_index_in, pc_in, inst_in, out_ready,
    input  in_ready, out_valid, is_branch_taken_out, pht_index_out, pc_out, inst_out, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction buffer between IF and ID: DEPTH-entry circular queue of {taken, pht_index, pc, inst}.
// Latency: a pushed entry is visible at the head one cycle later (no bypass); 1 push + 1 pop per cycle.
// Backpressure: in_ready drops when full (no same-cycle slot reuse) or on flush; head held until out_ready.
// Ports: clk, rst (async active-low), bus (fetch_queue_if.slave).
module fetch_queue #(
  parameter int DEPTH     = 8,   // power of two, >= 2
  parameter int GHR_WIDTH = 5
) (
  input  logic           clk,
  input  logic           rst,
  fetch_queue_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic                 taken;
    logic [GHR_WIDTH-1:0] pht_index;
    logic [31:0]          pc;
    logic [31:0]          inst;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          empty, full, push, pop;
  entry_t        head, wr_entry;

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    // Same slot index, opposite lap: the writer is a full lap ahead.
    full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // Handshake qualifiers come from pointers, rst and flush only, never from in_valid/out_ready.
    bus.in_ready  = rst & ~full  & ~bus.flush;
    bus.out_valid = rst & ~empty & ~bus.flush;

    push = bus.in_valid  & bus.in_ready;
    pop  = bus.out_valid & bus.out_ready;

    wr_entry = '{taken:     bus.is_branch_taken_in,
                 pht_index: bus.pht_index_in,
                 pc:        bus.pc_in,
                 inst:      bus.inst_in};

    // Head reads as all-zero (nop at pc 0) whenever it is not valid.
    head = bus.out_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    bus.is_branch_taken_out = head.taken;
    bus.pht_index_out       = head.pht_index;
    bus.pc_out              = head.pc;
    bus.inst_out            = head.inst;

    // Modular difference is exact across wraps because pointers carry one extra bit.
    bus.count = wr_ptr_q - rd_ptr_q;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage is never cleared: a stale slot is unreachable once the pointers say empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
  end
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int DEPTH = 8;
  localparam int GW    = 5;

  typedef struct packed {
    logic          taken;
    logic [GW-1:0] pht;
    logic [31:0]   pc;
    logic [31:0]   inst;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH), .GHR_WIDTH(GW)) bus ();
  fetch_queue #(.DEPTH(DEPTH), .GHR_WIDTH(GW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: a plain FIFO of entries ----------------
  ent_t model[$];
  logic p_push = 1'b0, p_pop = 1'b0, p_flush = 1'b0;
  ent_t p_ent;

  always @(negedge clk) begin
    logic exp_rdy, exp_vld;
    ent_t hd;
    if (!rst) begin
      model.delete();
      p_push = 1'b0; p_pop = 1'b0; p_flush = 1'b0;
      chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_count",     32'(bus.count),     32'd0);
      chk("rst_pc_out",    bus.pc_out,         32'd0);
      chk("rst_inst_out",  bus.inst_out,       32'd0);
    end else begin
      exp_rdy = !bus.flush && (model.size() < DEPTH);
      exp_vld = !bus.flush && (model.size() > 0);
      hd = exp_vld ? model[0] : '0;
      chk("m_in_ready",  32'(bus.in_ready),            32'(exp_rdy));
      chk("m_out_valid", 32'(bus.out_valid),           32'(exp_vld));
      chk("m_count",     32'(bus.count),               32'(model.size()));
      chk("m_taken",     32'(bus.is_branch_taken_out), 32'(hd.taken));
      chk("m_pht",       32'(bus.pht_index_out),       32'(hd.pht));
      chk("m_pc",        bus.pc_out,                   hd.pc);
      chk("m_inst",      bus.inst_out,                 hd.inst);
      p_flush = bus.flush;
      p_push  = bus.in_valid && exp_rdy;
      p_pop   = bus.out_ready && exp_vld;
      p_ent   = '{taken: bus.is_branch_taken_in, pht: bus.pht_index_in,
                  pc: bus.pc_in, inst: bus.inst_in};
    end
  end

  always @(posedge clk) begin
    if (!rst) model.delete();
    else if (p_flush) model.delete();
    else begin
      if (p_pop)  void'(model.pop_front());
      if (p_push) model.push_back(p_ent);
    end
    p_push = 1'b0; p_pop = 1'b0; p_flush = 1'b0;
  end

  always @(negedge rst) model.delete();

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    bus.in_valid           = v;
    bus.pc_in              = pc;
    bus.inst_in            = pc ^ 32'h2400_0000;
    bus.is_branch_taken_in = pc[2];
    bus.pht_index_in       = pc[6:2];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    logic acc;
    logic [31:0] bp_pc;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    drive(1'b0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rel_count",    32'(bus.count),    32'd0);
    tick();

    // --- single push / pop ---
    bus.in_valid = 1'b1; bus.pc_in = 32'hBFC0_0000; bus.inst_in = 32'h2408_0001;
    bus.is_branch_taken_in = 1'b0; bus.pht_index_in = 5'd3;
    #1;
    chk("t1_c1_out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    drive(1'b0, 32'd0);
    #1;
    chk("t1_c2_out_valid", 32'(bus.out_valid),     32'd1);
    chk("t1_c2_pc",        bus.pc_out,             32'hBFC0_0000);
    chk("t1_c2_inst",      bus.inst_out,           32'h2408_0001);
    chk("t1_c2_pht",       32'(bus.pht_index_out), 32'd3);
    chk("t1_c2_count",     32'(bus.count),         32'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    #1;
    chk("t1_c3_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t1_c3_count",     32'(bus.count),     32'd0);
    chk("t1_c3_inst",      bus.inst_out,       32'd0);

    // --- fill to full ---
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'(i * 4));
      tick();
    end
    drive(1'b1, 32'h20);
    #1;
    chk("t2_full_count",    32'(bus.count),    32'd8);
    chk("t2_full_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("t2_ninth_count", 32'(bus.count), 32'd8);
    bus.out_ready = 1'b1;
    #1;
    chk("t2_full_pop_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    drive(1'b0, 32'd0); bus.out_ready = 1'b0;
    #1;
    chk("t2_after_count", 32'(bus.count), 32'd7);
    chk("t2_after_head",  bus.pc_out,     32'h4);
    bus.out_ready = 1'b1;
    guard = 0;
    while (bus.count != 0 && guard < 20) begin tick(); guard++; end
    chk("t2_drain_done", 32'(bus.count), 32'd0);
    bus.out_ready = 1'b0;
    tick();

    // --- streaming across 5 pointer wraps ---
    for (int k = 0; k <= 40; k++) begin
      drive(k < 40, 32'h1000 + 32'(k * 4));
      bus.out_ready = (k > 0);
      #1;
      if (k > 0) begin
        chk("t3_count", 32'(bus.count), 32'd1);
        chk("t3_head",  bus.pc_out,     32'h1000 + 32'((k - 1) * 4));
      end
      tick();
    end
    drive(1'b0, 32'd0); bus.out_ready = 1'b0;
    #1;
    chk("t3_end_count", 32'(bus.count), 32'd0);

    // --- flush with simultaneous handshakes ---
    for (int i = 0; i < 5; i++) begin drive(1'b1, 32'h2000 + 32'(i * 4)); tick(); end
    chk("t4_pre_count", 32'(bus.count), 32'd5);
    bus.flush = 1'b1; bus.out_ready = 1'b1; drive(1'b1, 32'h2100);
    #1;
    chk("t4_flush_in_ready",  32'(bus.in_ready),  32'd0);
    chk("t4_flush_out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    bus.flush = 1'b0; bus.out_ready = 1'b0; drive(1'b0, 32'd0);
    #1;
    chk("t4_post_count",     32'(bus.count),     32'd0);
    chk("t4_post_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t4_post_in_ready",  32'(bus.in_ready),  32'd1);
    drive(1'b1, 32'h1234);
    tick();
    drive(1'b0, 32'd0);
    #1;
    chk("t4_next_valid", 32'(bus.out_valid), 32'd1);
    chk("t4_next_pc",    bus.pc_out,         32'h1234);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // --- asynchronous reset mid-stream ---
    for (int i = 0; i < 3; i++) begin drive(1'b1, 32'h3000 + 32'(i * 4)); tick(); end
    drive(1'b0, 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_async_count",     32'(bus.count),     32'd0);
    chk("t5_async_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_async_in_ready",  32'(bus.in_ready),  32'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("t5_rel_in_ready", 32'(bus.in_ready),  32'd1);
    chk("t5_rel_empty",    32'(bus.out_valid), 32'd0);
    tick();

    // --- back-pressure: out_ready alternates, in_valid held high ---
    bp_pc = 32'h4000;
    for (int c = 0; c < 30; c++) begin
      drive(1'b1, bp_pc);
      bus.out_ready = (c % 2 == 0);
      #1;
      acc = bus.in_ready;
      if (c >= 14) chk("t6_in_ready_toggle", 32'(acc), 32'(c % 2));
      tick();
      if (acc) bp_pc = bp_pc + 32'd4;
    end
    drive(1'b0, 32'd0); bus.out_ready = 1'b0;
    #1;
    chk("t6_full_count",    32'(bus.count),    32'd8);
    chk("t6_full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    guard = 0;
    while (bus.count != 0 && guard < 20) begin tick(); guard++; end
    chk("t6_drain_done", 32'(bus.count), 32'd0);
    bus.out_ready = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
